// File: rtl/omsr_pkg.sv
// Shared constants and types for the on-chip memory stream reader.
package omsr_pkg;

  localparam int MEM_WORDS        = 8192;
  localparam int ADDR_W           = $clog2(MEM_WORDS);
  localparam int DATA_W           = 32;
  // Cycles from chipselect to readdata on the memory's second port.
  localparam int MEM_READ_LATENCY = 1;

  // Sweep control: RUN covers issuing and draining, DONE is the one-cycle
  // completion pulse during which a new start is not accepted.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/omsr_fifo.sv
// Synchronous show-ahead FIFO: o_data always presents the head entry.
// Storage is not reset; only the pointers and occupancy are.
module omsr_fifo #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_push,
  input  logic [DATA_W-1:0]             i_data,
  input  logic                          i_pop,
  output logic [DATA_W-1:0]             o_data,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic                          o_empty
);
  import omsr_pkg::*;

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  // Entry storage: written on push, never cleared.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/onchip_mem_stream_reader.sv
// Avalon-MM read master that sweeps a contiguous word range of the on-chip
// memory and re-presents it as an Avalon-ST source with backpressure.
// Reads are only issued when the FIFO can absorb every outstanding response,
// so readdata is pushed unconditionally one latency after each chipselect.
module onchip_mem_stream_reader #(
  parameter int ADDR_W     = omsr_pkg::ADDR_W,
  parameter int DATA_W     = omsr_pkg::DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base,
  input  logic [ADDR_W:0]     count,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   address,
  output logic                chipselect,
  output logic                write,
  output logic [DATA_W/8-1:0] byteenable,
  output logic                clken,
  input  logic [DATA_W-1:0]   readdata,
  output logic [DATA_W-1:0]   st_data,
  output logic                st_valid,
  input  logic                st_ready,
  output logic                st_last
);
  import omsr_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int OCC_W = CNT_W + 1;
  localparam int LAT   = MEM_READ_LATENCY;

  localparam logic [ADDR_W:0]   LEFT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_start_accept;

  logic [ADDR_W-1:0] r_rd_addr;
  logic [ADDR_W-1:0] r_addr_hold;
  logic [ADDR_W:0]   r_rd_left;
  logic [ADDR_W:0]   r_out_left;
  // One bit per read still travelling through the memory pipeline.
  logic [LAT-1:0]    r_inflight;

  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic              w_last_pop;
  logic              w_fifo_empty;
  logic [CNT_W-1:0]  w_fifo_count;
  logic [DATA_W-1:0] w_fifo_data;
  logic [OCC_W-1:0]  w_occupancy;

  // Credit: words already buffered plus words still on their way back.
  assign w_occupancy = OCC_W'(w_fifo_count) + OCC_W'($countones(r_inflight));
  assign w_issue     = (r_state == RUN) && (r_rd_left != '0) &&
                       (w_occupancy < OCC_W'(FIFO_DEPTH));
  assign w_push      = r_inflight[LAT-1];

  assign st_valid    = !w_fifo_empty;
  assign st_data     = w_fifo_empty ? '0 : w_fifo_data;
  assign st_last     = st_valid && (r_out_left == LEFT_ONE);
  assign w_pop       = st_valid && st_ready;
  assign w_last_pop  = w_pop && st_last;

  assign busy        = (r_state == RUN);
  assign done        = (r_state == DONE);
  assign chipselect  = w_issue;
  // The address bus shows the issuing address, otherwise the last one used.
  assign address     = w_issue ? r_rd_addr : r_addr_hold;
  assign write       = 1'b0;
  assign byteenable  = '1;
  assign clken       = 1'b1;

  omsr_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (readdata),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_count (w_fifo_count),
    .o_empty (w_fifo_empty)
  );

  // Control state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; start is honoured only from IDLE.
  always_comb begin
    w_state_nxt    = r_state;
    w_start_accept = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_start_accept = 1'b1;
          w_state_nxt    = (count == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (w_last_pop) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Address, remaining-read and remaining-output counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_addr   <= '0;
      r_addr_hold <= '0;
      r_rd_left   <= '0;
      r_out_left  <= '0;
    end else if (w_start_accept) begin
      r_rd_addr  <= base;
      r_rd_left  <= count;
      r_out_left <= count;
    end else begin
      if (w_issue) begin
        r_rd_addr   <= r_rd_addr + ADDR_ONE;
        r_addr_hold <= r_rd_addr;
        r_rd_left   <= r_rd_left - LEFT_ONE;
      end
      if (w_pop) begin
        r_out_left <= r_out_left - LEFT_ONE;
      end
    end
  end

  // Read-latency tracker; clearing it drops any response still in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_inflight <= '0;
    end else begin
      r_inflight <= LAT'({r_inflight, w_issue});
    end
  end

endmodule

// File: doc/onchip_mem_stream_reader.md
# onchip_mem_stream_reader

Avalon-MM read master that drains a contiguous word range from the second port (s2) of the 8192 x 32 dual-port on-chip memory and presents it as an Avalon-ST source with backpressure. Sits between the on-chip frame/colour buffer and the Ambilight colour pipeline. A start pulse with base address and word count launches one burst-free, pipelined read sweep. A small internal FIFO keeps reads flowing at one word per cycle while the sink is ready.

## Interface
Parameters:
- ADDR_W, 13, memory word-address width (8192 words)
- DATA_W, 32, memory and stream data width
- FIFO_DEPTH, 4, output buffer depth, power of two, ≥ 2

Ports:
- clk  in  1  single clock, shared with the memory
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle launch request, ignored while busy
- base  in  ADDR_W  first word address, sampled with start
- count  in  ADDR_W+1  words to read, 0..8192, sampled with start
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at sweep completion
- address  out  ADDR_W  memory word address
- chipselect  out  1  read request, one word per asserted cycle
- write  out  1  constant 0
- byteenable  out  DATA_W/8  constant all-ones
- clken  out  1  constant 1
- readdata  in  DATA_W  memory data, valid the cycle after chipselect
- st_data  out  DATA_W  stream word
- st_valid  out  1  stream word valid
- st_ready  in  1  sink accepts word
- st_last  out  1  marks final word of sweep

## Operation
- Idle: busy=0. On start=1, latch base into rd_addr, count into rd_left and out_left, set busy next cycle.
- count=0: no reads issued; busy stays 0; done pulses the cycle after start.
- Issue rule: chipselect=1 when busy, rd_left≠0, and (fifo_count + inflight) < FIFO_DEPTH. On issue: address=rd_addr, rd_addr increments modulo 2^ADDR_W (8191 wraps to 0), rd_left decrements.
- inflight is a 1-bit register set on issue. readdata is pushed into the FIFO on the cycle inflight=1, unconditionally; the credit rule guarantees space.
- Stream: st_valid = FIFO non-empty; st_data = FIFO head; st_last = st_valid and out_left==1. Pop on st_valid & st_ready, decrementing out_left.
- Completion: pop with st_last → done=1 next cycle, busy=0 next cycle. A start arriving in that same cycle is ignored.
- Stream handshake: st_data and st_last stay stable while st_valid=1 and st_ready=0. st_valid is never withdrawn without acceptance.
- address holds its last value when chipselect=0. write, byteenable and clken are constant.
- Reset, including mid-sweep: FIFO flushed, inflight cleared, the pending memory response discarded, all counters zeroed.

## Timing
- Reset values: busy=0, done=0, chipselect=0, address=0, st_valid=0, st_last=0, st_data=0.
- start sampled at edge of cycle 0. busy=1 and first chipselect in cycle 1. readdata captured in cycle 2. st_valid=1 in cycle 3.
- With st_ready held at 1: one word per cycle. The last of N words is accepted in cycle N+2, and done pulses in cycle N+3.
- With st_ready=0: reads stall once fifo_count + inflight = FIFO_DEPTH. They resume in the cycle after a pop frees a slot.
- Simultaneous push and pop keep fifo_count unchanged.

## Structure
- Package omsr_pkg: ADDR_W, DATA_W, MEM_WORDS=8192, MEM_READ_LATENCY=1 constants; state enum {IDLE, RUN, DONE}.
- Sub-module omsr_fifo: synchronous show-ahead FIFO (push, pop, data, count, empty) with the same clk/reset, FIFO_DEPTH entries.
- Top holds the control FSM, address and credit counters, and the stream output logic. Target size is about 200 lines.

## Test plan
- Basic sweep: memory preloaded mem[i]=i; start base=16, count=8, st_ready=1 → st_data 16..23 in cycles 3..10, st_last only on 23, done in cycle 11.
- Wrap: base=8190, count=4 → addresses 8190, 8191, 0, 1; stream mem[8190], mem[8191], mem[0], mem[1].
- Backpressure: count=20, st_ready toggled at random with 30% high → all 20 words in order with no loss or duplication. chipselect never asserted while fifo_count + inflight = 4. Data held stable while stalled.
- Zero and full length: count=0 → no chipselect, done next cycle. count=8192, base=5 → 8192 words, last word mem[4], exactly one done.
- Ignored start: start pulsed mid-sweep with a different base → stream unchanged. Start on the done cycle → ignored; start one cycle later → accepted.
- Reset mid-sweep: reset asserted one cycle while inflight=1 and FIFO holds 3 words → next cycle busy=0, st_valid=0, chipselect=0. A subsequent start of count=2 streams exactly 2 correct words.
